alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Initiator side of the ALU interface: accepts commands from decode over a valid/ready
//   handshake, drives the combinational ALU's input_a/input_b/operation, registers the
//   result and returns it over a valid/ready response channel. Single ops pass straight
//   through; unsigned multiply is sequenced as iterative shift-and-add using ALU add.
// PARAMETERS
//   WORDSIZE  64  data width; must match the ALU instance
//   CNTW      7   iteration counter width; >= clog2(WORDSIZE)+1
// PORTS
//   clk            in   1         single clock; all state updates on rising edge
//   rst_n          in   1         synchronous, active-low reset
//   cmd_valid      in   1         command present
//   cmd_ready      out  1         sequencer can accept (IDLE only)
//   cmd_mul        in   1         1 = unsigned multiply; cmd_op ignored
//   cmd_op         in   6         ALU operation code (single-op mode)
//   cmd_a          in   WORDSIZE  operand A / multiplicand
//   cmd_b          in   WORDSIZE  operand B / multiplier
//   alu_input_a    out  WORDSIZE  to ALU input_a
//   alu_input_b    out  WORDSIZE  to ALU input_b
//   alu_operation  out  6         to ALU operation
//   alu_result     in   WORDSIZE  from ALU result (same-cycle combinational)
//   alu_overflow   in   1         from ALU flag_overflow
//   rsp_valid      out  1         response present
//   rsp_ready      in   1         consumer accepts response
//   rsp_result     out  WORDSIZE  result
//   rsp_overflow   out  1         overflow indication
//   busy           out  1         state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, rsp_valid=0, rsp_result=0, rsp_overflow=0,
//     all operand/acc/counter regs=0. Reset mid-operation abandons it; no response issued.
//   ALU drive: IDLE/RESP -> alu_input_a=0, alu_input_b=0, alu_operation=6'b000000;
//     EXEC -> op_q, a_q, b_q; MUL -> add (6'b000000), acc, mcand.
//   States: IDLE -> EXEC | MUL -> RESP -> IDLE.
//   IDLE: cmd_ready=1. cmd_valid=1 at edge: latch a_q=cmd_a, b_q=cmd_b, op_q=cmd_op;
//     for mul also acc=0, mcand=cmd_a, mplier=cmd_b, cnt=0, ovf=0. -> MUL if cmd_mul else EXEC.
//   EXEC (1 cycle): rsp_result<=alu_result, rsp_overflow<=alu_overflow; -> RESP.
//   MUL (per cycle): if mplier[0]: acc<=alu_result, ovf|=alu_overflow.
//     ovf|=mcand[WORDSIZE-1] & (mplier>>1 != 0); mcand<=mcand<<1; mplier<=mplier>>1; cnt++.
//     Exit to RESP when (mplier>>1)==0 or cnt==WORDSIZE-1; rsp_result<=updated acc,
//     rsp_overflow<=updated ovf. Result = low WORDSIZE bits of unsigned a*b.
//   Latency (accept edge = N): single op rsp_valid high from N+2; multiply from N+1+k,
//     k = index of highest set bit of cmd_b + 1 (k=1 when cmd_b==0; max WORDSIZE).
//   RESP: rsp_valid=1; rsp_result/rsp_overflow stable while rsp_valid && !rsp_ready.
//     rsp_ready=1 at edge -> IDLE, rsp_valid=0 next cycle. cmd_ready=0 in RESP, so
//     back-to-back throughput is one command per >=3 cycles.
//   cmd_* sampled only at accept; later changes have no effect. Handshakes never
//     depend combinationally on the other side (cmd_ready, rsp_valid are state decodes).
// TESTING (WORDSIZE=64, real ALU instance)
//   Reset: rst_n=0 two cycles -> rsp_valid=0, cmd_ready=1, busy=0, alu_operation=0.
//   Single op: cmd_op=add, a=5, b=7 accepted at N -> rsp_valid at N+2, rsp_result=12.
//   Multiply: a=3, b=6 -> rsp_result=18, rsp_valid at N+4 (k=3); b=0 -> 0 at N+2.
//   Multiply overflow: a=2^63, b=2 -> rsp_result=0, rsp_overflow=1;
//     a=b=0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001, k=32.
//   Backpressure: hold rsp_ready=0 10 cycles -> outputs stable, cmd_ready=0, new
//     cmd_valid ignored; release -> IDLE next cycle, then new command accepted.
//   Reset mid-multiply (b=2^63, rst_n=0 at cycle 20) -> IDLE, no rsp_valid ever raised.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command/response front end for a combinational ALU.
// Single operations pass through in one cycle; unsigned multiply is
// sequenced as shift-and-add, reusing the ALU adder for each partial sum.
module alu_sequencer #(
    parameter int WORDSIZE = 64,
    parameter int CNTW     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mul,
    input  logic [5:0]          cmd_op,
    input  logic [WORDSIZE-1:0] cmd_a,
    input  logic [WORDSIZE-1:0] cmd_b,
    output logic [WORDSIZE-1:0] alu_input_a,
    output logic [WORDSIZE-1:0] alu_input_b,
    output logic [5:0]          alu_operation,
    input  logic [WORDSIZE-1:0] alu_result,
    input  logic                alu_overflow,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_result,
    output logic                rsp_overflow,
    output logic                busy
);

    localparam logic [5:0] OP_ADD = 6'b000000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RESP
    } state_t;

    state_t              state;
    logic [WORDSIZE-1:0] a_q;
    logic [WORDSIZE-1:0] b_q;
    logic [5:0]          op_q;
    logic [WORDSIZE-1:0] acc;
    logic [WORDSIZE-1:0] mcand;
    logic [WORDSIZE-1:0] mplier;
    logic [CNTW-1:0]     cnt;
    logic                ovf;

    logic [WORDSIZE-1:0] mplier_sh;
    logic [WORDSIZE-1:0] acc_nx;
    logic                ovf_nx;
    logic                mul_done;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // One multiply step: conditional accumulate plus overflow from carry-out
    // or from a multiplicand bit shifted out while multiplier bits remain.
    always_comb begin
        mplier_sh = mplier >> 1;
        acc_nx    = mplier[0] ? alu_result : acc;
        ovf_nx    = ovf | (mplier[0] & alu_overflow)
                        | (mcand[WORDSIZE-1] & (mplier_sh != '0));
        mul_done  = (mplier_sh == '0) || (cnt == CNTW'(WORDSIZE - 1));
    end

    // ALU operand/operation drive decoded from the current state.
    always_comb begin
        alu_input_a   = '0;
        alu_input_b   = '0;
        alu_operation = OP_ADD;
        case (state)
            EXEC: begin
                alu_input_a   = a_q;
                alu_input_b   = b_q;
                alu_operation = op_q;
            end
            MUL: begin
                alu_input_a   = acc;
                alu_input_b   = mcand;
                alu_operation = OP_ADD;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q  <= cmd_a;
                        b_q  <= cmd_b;
                        op_q <= cmd_op;
                        if (cmd_mul) begin
                            acc    <= '0;
                            mcand  <= cmd_a;
                            mplier <= cmd_b;
                            cnt    <= '0;
                            ovf    <= 1'b0;
                            state  <= MUL;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_overflow <= alu_overflow;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                MUL: begin
                    acc    <= acc_nx;
                    ovf    <= ovf_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    cnt    <= cnt + 1'b1;
                    if (mul_done) begin
                        rsp_result   <= acc_nx;
                        rsp_overflow <= ovf_nx;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
